// File: rtl/dmem_port_arbiter_pkg.sv
// Shared owner encoding and default bus widths for the data-memory port arbiter.
// Widths match the core data port and the cached-memory user port.
package dmem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WE_W   = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_A    = 2'd1,
        OWNER_B    = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_port_if.sv
// One memory-style request port: requester drives ren/wen/addr/wdata and holds them
// until an edge with stall low; rdata is valid in that completing cycle.
interface dmem_port_if #(
    parameter int ADDR_W = dmem_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W = dmem_port_arbiter_pkg::DATA_W,
    parameter int WE_W   = dmem_port_arbiter_pkg::WE_W
);
    logic              ren;
    logic [WE_W-1:0]   wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              stall;

    modport master (output ren, wen, addr, wdata, input rdata, stall);
    modport slave  (input ren, wen, addr, wdata, output rdata, stall);
endinterface

// File: rtl/dmem_req_mux.sv
// Combinational 2:1 request mux onto the memory port; zero latency.
// No selection drives an all-zero idle request.
module dmem_req_mux #(
    parameter int ADDR_W = dmem_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W = dmem_port_arbiter_pkg::DATA_W,
    parameter int WE_W   = dmem_port_arbiter_pkg::WE_W
) (
    input  dmem_port_arbiter_pkg::owner_e i_sel,
    input  logic              i_a_ren,
    input  logic [WE_W-1:0]   i_a_wen,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_b_ren,
    input  logic [WE_W-1:0]   i_b_wen,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_m_ren,
    output logic [WE_W-1:0]   o_m_wen,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_data
);
    import dmem_port_arbiter_pkg::*;

    always_comb begin
        o_m_ren  = 1'b0;
        o_m_wen  = '0;
        o_m_addr = '0;
        o_m_data = '0;
        case (i_sel)
            OWNER_A: begin
                o_m_ren  = i_a_ren;
                o_m_wen  = i_a_wen;
                o_m_addr = i_a_addr;
                o_m_data = i_a_data;
            end
            OWNER_B: begin
                o_m_ren  = i_b_ren;
                o_m_wen  = i_b_wen;
                o_m_addr = i_b_addr;
                o_m_data = i_b_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the cached data memory: A has priority, B wins after B_WAIT_MAX
// waiting cycles; zero-latency grant, grant locked while memory stalls, A masked until init done.
module dmem_port_arbiter #(
    parameter int ADDR_W     = dmem_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W     = dmem_port_arbiter_pkg::DATA_W,
    parameter int WE_W       = dmem_port_arbiter_pkg::WE_W,
    parameter int B_WAIT_MAX = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_init_done,
    dmem_port_if.slave  a_if,
    dmem_port_if.slave  b_if,
    dmem_port_if.master m_if,
    output logic [1:0]  o_owner
);
    import dmem_port_arbiter_pkg::*;

    owner_e     r_owner;
    owner_e     w_owner_nxt;
    owner_e     w_sel;
    logic [7:0] r_b_wait;
    logic [7:0] w_b_wait_nxt;
    logic       w_a_req;
    logic       w_b_req;
    logic       w_a_req_eff;
    logic       w_b_starved;
    logic       w_b_done;

    assign w_a_req     = a_if.ren | (|a_if.wen);
    assign w_b_req     = b_if.ren | (|b_if.wen);
    assign w_a_req_eff = w_a_req & i_init_done;
    assign w_b_starved = int'(r_b_wait) >= B_WAIT_MAX;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner <= OWNER_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Lock only while the memory stalls; any completion frees the port for the next cycle.
    always_comb begin
        w_owner_nxt = OWNER_NONE;
        if ((w_sel != OWNER_NONE) && m_if.stall) begin
            w_owner_nxt = w_sel;
        end
    end

    // Reset forces the idle selection so the memory sees nothing while rst is high.
    always_comb begin
        w_sel = OWNER_NONE;
        if (i_rst) begin
            w_sel = OWNER_NONE;
        end else if (r_owner != OWNER_NONE) begin
            w_sel = r_owner;
        end else if (w_b_req && (w_b_starved || !w_a_req_eff)) begin
            w_sel = OWNER_B;
        end else if (w_a_req_eff) begin
            w_sel = OWNER_A;
        end
    end

    assign a_if.stall = w_a_req & ~((w_sel == OWNER_A) & ~m_if.stall);
    assign b_if.stall = w_b_req & ~((w_sel == OWNER_B) & ~m_if.stall);
    assign a_if.rdata = m_if.rdata;
    assign b_if.rdata = m_if.rdata;
    assign o_owner    = r_owner;

    assign w_b_done = (w_sel == OWNER_B) & ~m_if.stall;

    // B stalled behind its own locked transaction neither ages nor clears.
    always_comb begin
        w_b_wait_nxt = r_b_wait;
        if (!w_b_req || w_b_done) begin
            w_b_wait_nxt = 8'd0;
        end else if ((w_sel != OWNER_B) && (r_b_wait != 8'hFF)) begin
            w_b_wait_nxt = r_b_wait + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_b_wait <= 8'd0;
        end else begin
            r_b_wait <= w_b_wait_nxt;
        end
    end

    dmem_req_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WE_W   (WE_W)
    ) u_req_mux (
        .i_sel    (w_sel),
        .i_a_ren  (a_if.ren),
        .i_a_wen  (a_if.wen),
        .i_a_addr (a_if.addr),
        .i_a_data (a_if.wdata),
        .i_b_ren  (b_if.ren),
        .i_b_wen  (b_if.wen),
        .i_b_addr (b_if.addr),
        .i_b_data (b_if.wdata),
        .o_m_ren  (m_if.ren),
        .o_m_wen  (m_if.wen),
        .o_m_addr (m_if.addr),
        .o_m_data (m_if.wdata)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed scenarios plus a randomized phase, every cycle compared against a transaction-level model.
module tb_dmem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done;
    logic [1:0] owner;

    dmem_port_if a_if ();
    dmem_port_if b_if ();
    dmem_port_if m_if ();

    dmem_port_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_init_done (init_done),
        .a_if        (a_if),
        .b_if        (b_if),
        .m_if        (m_if),
        .o_owner     (owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who holds the port (0 free, 1 A, 2 B) and how many edges B has been passed over.
    int mdl_owner = 0;
    int mdl_wait  = 0;
    int cur_sel   = 0;
    bit a_done, b_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit a_req();
        return a_if.ren | (|a_if.wen);
    endfunction

    function automatic bit b_req();
        return b_if.ren | (|b_if.wen);
    endfunction

    task automatic check_all();
        bit          ae;
        logic        eren;
        logic [3:0]  ewen;
        logic [31:0] eaddr, edata;
        if (rst) begin
            mdl_owner = 0;
            mdl_wait  = 0;
        end
        ae = a_req() & init_done;
        if (rst)                                          cur_sel = 0;
        else if (mdl_owner != 0)                          cur_sel = mdl_owner;
        else if (b_req() && (mdl_wait >= 8 || !ae))       cur_sel = 2;
        else if (ae)                                      cur_sel = 1;
        else                                              cur_sel = 0;
        eren = 1'b0; ewen = 4'h0; eaddr = 32'h0; edata = 32'h0;
        if (cur_sel == 1) begin
            eren = a_if.ren; ewen = a_if.wen; eaddr = a_if.addr; edata = a_if.wdata;
        end else if (cur_sel == 2) begin
            eren = b_if.ren; ewen = b_if.wen; eaddr = b_if.addr; edata = b_if.wdata;
        end
        chk("m_ren",   m_if.ren,   eren);
        chk("m_wen",   m_if.wen,   ewen);
        chk("m_addr",  m_if.addr,  eaddr);
        chk("m_data",  m_if.wdata, edata);
        chk("a_stall", a_if.stall, a_req() && !(cur_sel == 1 && !m_if.stall));
        chk("b_stall", b_if.stall, b_req() && !(cur_sel == 2 && !m_if.stall));
        chk("owner",   owner,      mdl_owner);
        chk("a_rdata", a_if.rdata, m_if.rdata);
        chk("b_rdata", b_if.rdata, m_if.rdata);
    endtask

    task automatic advance();
        a_done = !rst && a_req() && cur_sel == 1 && !m_if.stall;
        b_done = !rst && b_req() && cur_sel == 2 && !m_if.stall;
        if (!rst) begin
            if (cur_sel != 0) mdl_owner = m_if.stall ? cur_sel : 0;
            if (!b_req() || b_done)                 mdl_wait = 0;
            else if (cur_sel != 2 && mdl_wait < 255) mdl_wait++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        #4;
        check_all();
        advance();
    endtask

    task automatic set_a(input logic ren, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
        a_if.ren = ren; a_if.wen = wen; a_if.addr = addr; a_if.wdata = data;
    endtask

    task automatic set_b(input logic ren, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
        b_if.ren = ren; b_if.wen = wen; b_if.addr = addr; b_if.wdata = data;
    endtask

    // Random requester state: a held transaction persists until the model says it completed.
    logic        ra_act, rb_act;
    logic        ra_ren, rb_ren;
    logic [3:0]  ra_wen, rb_wen;
    logic [31:0] ra_addr, rb_addr, ra_data, rb_data;

    task automatic new_txn(output logic ren, output logic [3:0] wen, output logic [31:0] addr, output logic [31:0] data);
        int kind;
        kind = $urandom_range(0, 3);
        ren  = (kind == 0 || kind == 2 || kind == 3);
        wen  = (kind == 1 || kind == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
        addr = $urandom;
        data = $urandom;
    endtask

    initial begin
        int  grant_k;
        rst = 1'b1;
        init_done = 1'b1;
        set_a(1'b0, 4'h0, 32'h0, 32'h0);
        set_b(1'b0, 4'h0, 32'h0, 32'h0);
        m_if.rdata = 32'h0;
        m_if.stall = 1'b0;
        @(posedge clk);
        #1;
        // Reset state with junk on idle requesters
        a_if.addr = 32'hFFFF_FFFC; b_if.wdata = 32'hA5A5_A5A5;
        #4;
        check_all();
        chk("rst_owner", owner, 2'd0);
        chk("rst_m_addr", m_if.addr, 32'h0);
        advance();
        rst = 1'b0;

        // 1: lone A read completes with zero latency
        set_a(1'b1, 4'h0, 32'h40, 32'h0);
        m_if.rdata = 32'hCAFE_0001;
        #4;
        check_all();
        chk("t1_m_ren", m_if.ren, 1'b1);
        chk("t1_m_addr", m_if.addr, 32'h40);
        chk("t1_a_stall", a_if.stall, 1'b0);
        chk("t1_a_rdata", a_if.rdata, 32'hCAFE_0001);
        advance();
        set_a(1'b0, 4'h0, 32'h0, 32'h0);
        #4;
        check_all();
        chk("t1_owner_after", owner, 2'd0);
        advance();

        // 2: A write locked through 3 stall cycles, B waits then gets next cycle
        set_a(1'b0, 4'hF, 32'h80, 32'hDEAD_BEEF);
        m_if.stall = 1'b1;
        tick();
        set_b(1'b1, 4'h0, 32'h300, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) m_if.stall = 1'b0;
            #4;
            check_all();
            chk("t2_owner_lock", owner, 2'd1);
            chk("t2_b_stall", b_if.stall, 1'b1);
            chk("t2_m_addr", m_if.addr, 32'h80);
            chk("t2_m_data", m_if.wdata, 32'hDEAD_BEEF);
            chk("t2_m_wen", m_if.wen, 4'hF);
            advance();
        end
        set_a(1'b0, 4'h0, 32'h0, 32'h0);
        #4;
        check_all();
        chk("t2_b_grant", b_if.stall, 1'b0);
        chk("t2_b_addr", m_if.addr, 32'h300);
        advance();
        set_b(1'b0, 4'h0, 32'h0, 32'h0);

        // 3: A masked until init done
        init_done = 1'b0;
        set_a(1'b1, 4'h0, 32'h44, 32'h0);
        set_b(1'b0, 4'hF, 32'h100, 32'h1234_5678);
        #4;
        check_all();
        chk("t3_b_stall", b_if.stall, 1'b0);
        chk("t3_a_stall", a_if.stall, 1'b1);
        chk("t3_m_data", m_if.wdata, 32'h1234_5678);
        chk("t3_m_addr", m_if.addr, 32'h100);
        advance();
        set_b(1'b0, 4'h0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #4;
            check_all();
            chk("t3_a_masked", a_if.stall, 1'b1);
            chk("t3_m_idle", m_if.ren, 1'b0);
            advance();
        end
        init_done = 1'b1;
        #4;
        check_all();
        chk("t3_a_grant", a_if.stall, 1'b0);
        chk("t3_a_addr", m_if.addr, 32'h44);
        advance();

        // 4: A every cycle, B wins on its 9th pending cycle
        set_b(1'b1, 4'h0, 32'h500, 32'h0);
        grant_k = 0;
        for (int k = 1; k <= 20; k++) begin
            #4;
            check_all();
            if (!b_if.stall && grant_k == 0) grant_k = k;
            advance();
            if (grant_k != 0) break;
        end
        chk("t4_grant_cycle", grant_k, 9);
        set_b(1'b0, 4'h0, 32'h0, 32'h0);
        #4;
        check_all();
        chk("t4_wait_clear", dut.r_b_wait, 8'd0);
        advance();
        set_a(1'b0, 4'h0, 32'h0, 32'h0);

        // 5: async reset while B holds a locked grant
        set_b(1'b1, 4'h0, 32'h200, 32'h0);
        m_if.stall = 1'b1;
        tick();
        #4;
        check_all();
        chk("t5_owner_b", owner, 2'd2);
        advance();
        rst = 1'b1;
        #1;
        chk("t5_rst_owner", owner, 2'd0);
        chk("t5_rst_ren", m_if.ren, 1'b0);
        chk("t5_rst_wen", m_if.wen, 4'h0);
        chk("t5_rst_bstall", b_if.stall, 1'b1);
        #3;
        check_all();
        advance();
        rst = 1'b0;
        m_if.stall = 1'b0;
        #4;
        check_all();
        chk("t5_regrant", b_if.stall, 1'b0);
        chk("t5_regrant_addr", m_if.addr, 32'h200);
        advance();
        set_b(1'b0, 4'h0, 32'h0, 32'h0);

        // 6: idle
        for (int c = 0; c < 10; c++) begin
            #4;
            check_all();
            chk("t6_idle_ren", m_if.ren, 1'b0);
            chk("t6_idle_stall", {a_if.stall, b_if.stall}, 2'b00);
            advance();
        end

        // Randomized traffic
        ra_act = 1'b0; rb_act = 1'b0;
        a_done = 1'b0; b_done = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (a_done) ra_act = 1'b0;
            if (b_done) rb_act = 1'b0;
            if (!ra_act && $urandom_range(0, 2) != 0) begin
                new_txn(ra_ren, ra_wen, ra_addr, ra_data);
                ra_act = 1'b1;
            end
            if (!rb_act && $urandom_range(0, 3) == 0) begin
                new_txn(rb_ren, rb_wen, rb_addr, rb_data);
                rb_act = 1'b1;
            end
            if (ra_act) set_a(ra_ren, ra_wen, ra_addr, ra_data);
            else        set_a(1'b0, 4'h0, $urandom, $urandom);
            if (rb_act) set_b(rb_ren, rb_wen, rb_addr, rb_data);
            else        set_b(1'b0, 4'h0, $urandom, $urandom);
            m_if.stall = ($urandom_range(0, 2) == 0);
            m_if.rdata = $urandom;
            if ($urandom_range(0, 49) == 0) init_done = ~init_done;
            if (c > 450) init_done = 1'b1;
            rst = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Two-requester arbiter in front of the shared cached data memory (m_cached_memory user port).
- Requester A is the MIPS core data port; requester B is a loader/debug master (memory preload, result dump).
- Multiplexes one request at a time onto the memory port and locks the grant while the memory stalls.
- Gives A priority, with bounded-wait fairness for B. Keeps A off the port until memory initialisation is signalled done.

Parameters:
ADDR_W, 32, address width (word-aligned byte address; bits [1:0] forwarded unchanged)
DATA_W, 32, data width
WE_W, 4, byte write-enable width
B_WAIT_MAX, 8, consecutive cycles B may wait with a pending request before it wins the next free arbitration (1..255)

Ports:
Interface: one clock; reset is asynchronous and active-high (i_clk, i_rst).
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_init_done  in  1  memory init complete; while 0, A requests are masked (held stalled)
i_a_ren  in  1  A read request
i_a_wen  in  WE_W  A byte write enables
i_a_addr  in  ADDR_W  A address
i_a_data  in  DATA_W  A write data
o_a_data  out  DATA_W  A read data
o_a_stall  out  1  A must hold its request
i_b_ren, i_b_wen, i_b_addr, i_b_data, o_b_data, o_b_stall  same as A, for B
o_m_ren  out  1  memory read request
o_m_wen  out  WE_W  memory write enables
o_m_addr  out  ADDR_W  memory address
o_m_data  out  DATA_W  memory write data
i_m_data  in  DATA_W  memory read data
i_m_stall  in  1  memory busy
o_owner  out  2  registered lock owner (0 none, 1 A, 2 B)

Behaviour:
- Request definition: x_req = i_x_ren | (|i_x_wen). a_req_eff = a_req & i_init_done.
- Protocol, all sides: a requester holds ren/wen/addr/data stable until a rising edge where its stall is 0. That edge completes the transaction. Read data is valid in the completing cycle.
- Registered state:
  - r_owner in {NONE, A, B}; reset NONE.
  - r_b_wait, 8 bits; reset 0.
- Combinational select (sel):
  - r_owner != NONE -> sel = r_owner.
  - Else if B pending and (r_b_wait >= B_WAIT_MAX or !a_req_eff) -> sel = B.
  - Else if a_req_eff -> sel = A.
  - Else NONE.
- Memory outputs are a mux of the selected requester's signals. sel = NONE -> ren=0, wen=0, addr=0, data=0.
- o_a_data = o_b_data = i_m_data, unmasked. Consumers sample only at completion.
- Stall outputs:
  - o_a_stall = a_req & ~(sel==A & ~i_m_stall).
  - o_b_stall = b_req & ~(sel==B & ~i_m_stall).
  - A request with i_init_done=0 is stalled indefinitely.
- Zero-latency grant: a free port with a single request completes in the same cycle if i_m_stall=0. No arbitration bubble.
- Edge update:
  - sel != NONE and i_m_stall=1 -> r_owner <= sel (lock).
  - sel != NONE and i_m_stall=0 -> r_owner <= NONE.
  - sel = NONE -> r_owner stays NONE.
- Lock guarantee: the locked requester's signals are forwarded even if the other requester asserts meanwhile. No preemption.
- r_b_wait:
  - Increments (saturating at 255) each edge where b_req=1 and sel != B.
  - Clears on each edge where B completes, or where b_req=0.
- Simultaneous ren and wen from one requester: forwarded unchanged; memory defines the result.
- Reset mid-transaction: r_owner and r_b_wait cleared asynchronously. While i_rst=1, all o_m_* are forced 0 and o_x_stall = x_req. The in-flight memory transaction is abandoned; the requester must reissue.
- Reset values: o_owner=0, o_m_ren=0, o_m_wen=0, o_m_addr=0, o_m_data=0.

Decomposition:
- Shared package holds:
  - OWNER_NONE=2'd0, OWNER_A=2'd1, OWNER_B=2'd2.
  - Default widths ADDR_W/DATA_W/WE_W, matching the core and cached-memory defines.
- One natural sub-module: dmem_req_mux, the purely combinational 2:1 request mux driven by sel.
- FSM and counter stay in the top.

Test Plan:
1. A read, addr 0x40, memory stall 0 -> o_m_ren=1, o_m_addr=0x40 same cycle; o_a_stall=0; o_owner stays 0.
2. A write, wen=4'hF, addr 0x80, data 0xDEADBEEF; memory stalls 3 cycles; B raises a read at cycle 1 -> o_owner=1 for 3 cycles; o_m_* hold A values; o_b_stall=1. B is granted on the cycle after A completes.
3. i_init_done=0; A read and B write 0x100/0x12345678 both pending -> B completes; A stalled throughout. Raise i_init_done -> A is granted next.
4. A requests every cycle; B read pending, B_WAIT_MAX=8, memory stall 0 -> B is granted exactly on its 9th pending cycle; r_b_wait returns to 0.
5. Assert i_rst while o_owner=2 and i_m_stall=1 -> o_owner=0 and o_m_ren=o_m_wen=0 immediately (asynchronous). After release, B's held request is re-granted.
6. No requests for 10 cycles -> all o_m_* = 0, both stalls 0, o_owner=0.
